// File: rtl/seg7_scan_ctrl_if.sv
// KCPSM3 output-port write bus as seen by port-mapped peripherals.
// The processor side drives it and the peripheral side only listens.
interface seg7_scan_ctrl_if;
   logic [7:0] port_id;
   logic       write_strobe;
   logic [7:0] out_port;

   modport master (output port_id, output write_strobe, output out_port);
   modport slave  (input  port_id, input  write_strobe, input  out_port);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Port-mapped 4-digit multiplexed common-anode seven-segment driver with double-buffered registers.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
   parameter logic [7:0]  BASE_ADDR   = 8'h00,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic               CLK1,
   input  logic               arst,
   seg7_scan_ctrl_if.slave    kbus,
   output logic [0:6]         seg,
   output logic [3:0]         an
);

   localparam int unsigned         DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_t;

   typedef struct packed {
      logic [3:0][3:0] digit;
      logic [3:0]      mask;
      logic            en;
   } disp_regs_t;

   localparam disp_regs_t REGS_RESET = '{digit: '0, mask: 4'hF, en: 1'b1};

   function automatic logic [0:6] hex7(input logic [3:0] d);
      case (d)
         4'h0:    hex7 = 7'b0000001;
         4'h1:    hex7 = 7'b1001111;
         4'h2:    hex7 = 7'b0010010;
         4'h3:    hex7 = 7'b0000110;
         4'h4:    hex7 = 7'b1001100;
         4'h5:    hex7 = 7'b0100100;
         4'h6:    hex7 = 7'b0100000;
         4'h7:    hex7 = 7'b0001111;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0000100;
         4'hA:    hex7 = 7'b0001000;
         4'hB:    hex7 = 7'b1100000;
         4'hC:    hex7 = 7'b0110001;
         4'hD:    hex7 = 7'b1000010;
         4'hE:    hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   disp_regs_t       shadow, active;
   logic [DIV_W-1:0] div_cnt;
   logic             tick, frame_end;
   slot_t            slot, slot_nxt;
   logic [1:0]       slot_idx;
   logic [3:0]       cur_digit;
   logic [3:0]       lz_blank;
   logic             lit;
   logic [3:0]       an_nxt;
   logic [0:6]       seg_nxt;

   wire unused_ctrl_bits = ^kbus.out_port[7:5];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK1 or posedge arst) begin
      if (arst) begin
         shadow <= REGS_RESET;
      end else if (kbus.write_strobe) begin
         case (kbus.port_id)
            BASE_ADDR:         {shadow.digit[1], shadow.digit[0]} <= kbus.out_port;
            BASE_ADDR + 8'd1:  {shadow.digit[3], shadow.digit[2]} <= kbus.out_port;
            BASE_ADDR + 8'd2: begin
               shadow.mask <= kbus.out_port[3:0];
               shadow.en   <= kbus.out_port[4];
            end
            default: ;
         endcase
      end
   end

   assign tick      = (div_cnt == DIV_LAST);
   assign frame_end = tick && (slot == SLOT3);

   always_ff @(posedge CLK1 or posedge arst) begin
      if (arst) begin
         div_cnt <= '0;
         slot    <= SLOT0;
         active  <= REGS_RESET;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         slot    <= slot_nxt;
         // A write landing on the boundary cycle is still in flight and waits a frame.
         if (frame_end) active <= shadow;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      slot_nxt = slot;
      if (tick) begin
         case (slot)
            SLOT0:   slot_nxt = SLOT1;
            SLOT1:   slot_nxt = SLOT2;
            SLOT2:   slot_nxt = SLOT3;
            default: slot_nxt = SLOT0;
         endcase
      end
   end

   assign slot_idx  = slot;
   assign cur_digit = active.digit[slot_idx];

`ifdef SEG7_LZ_BLANK_EN
   // A digit is a leading zero only if it and every more-significant digit are zero.
   always_comb begin
      lz_blank    = '0;
      lz_blank[3] = (active.digit[3] == 4'h0);
      lz_blank[2] = lz_blank[3] && (active.digit[2] == 4'h0);
      lz_blank[1] = lz_blank[2] && (active.digit[1] == 4'h0);
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      lit     = active.en && active.mask[slot_idx] && !lz_blank[slot_idx];
      an_nxt  = 4'hF;
      seg_nxt = 7'b1111111;
      if (lit) begin
         an_nxt  = ~(4'b0001 << slot_idx);
         seg_nxt = hex7(cur_digit);
      end
   end

   always_ff @(posedge CLK1 or posedge arst) begin
      if (arst) begin
         an  <= 4'hF;
         seg <= 7'b1111111;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule
